btb_2bit_pred: RTL and testbench



---
 rtl/btb_pkg.sv | 23 ++
 rtl/btb_tag_cmp.sv | 14 +
 rtl/btb_2bit_pred.sv | 151 +++++++++++++++
 tb/tb_btb_2bit_pred.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: direction counter
// encoding and its saturating update rule.
package btb_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t SN = 2'b00;
   localparam ctr_t WN = 2'b01;
   localparam ctr_t WT = 2'b10;
   localparam ctr_t ST = 2'b11;

   // Counter MSB is the predicted direction; the count saturates at SN and ST.
   function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
      ctr_t next_ctr;
      if (taken) begin
         next_ctr = (ctr == ST) ? ST : ctr + 2'd1;
      end else begin
         next_ctr = (ctr == SN) ? SN : ctr - 2'd1;
      end
      return next_ctr;
   endfunction

endpackage

// File: rtl/btb_tag_cmp.sv
// Combinational hit detect for one table entry: the entry must be valid and
// its stored tag must equal the tag field of the presented PC.
module btb_tag_cmp #(
   parameter int TAG_W = 4
) (
   input  logic             entry_valid,
   input  logic [TAG_W-1:0] entry_tag,
   input  logic [TAG_W-1:0] pc_tag,
   output logic             match
);

   assign match = entry_valid & (entry_tag == pc_tag);

endmodule

// File: rtl/btb_2bit_pred.sv
// Direct-mapped branch target buffer with a 2-bit direction counter per entry.
// Predictions are registered one cycle after the lookup; updates come from execute.
module btb_2bit_pred
   import btb_pkg::*;
#(
   parameter int   PC_W     = 32,
   parameter int   IDX_W    = 4,
   parameter int   TAG_W    = 4,
   parameter ctr_t CTR_INIT = WT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            lookup_valid_i,
   input  logic [PC_W-1:0] lookup_pc_i,
   output logic            pred_valid_o,
   output logic            pred_hit_o,
   output logic            pred_taken_o,
   output logic [PC_W-1:0] pred_target_o,
   input  logic            upd_valid_i,
   input  logic [PC_W-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [PC_W-1:0] upd_target_i,
   input  logic            flush_i
);

   localparam int ENTRIES = 2 ** IDX_W;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      ctr_t             ctr;
      logic [PC_W-1:0]  target;
   } entry_t;

   if (IDX_W + TAG_W + 2 > PC_W) begin : g_bad_fields
      $error("btb_2bit_pred: IDX_W + TAG_W + 2 must not exceed PC_W");
   end

   // Valid and counter state is reset; tag and target are plain storage.
   logic            valid_q  [ENTRIES];
   ctr_t            ctr_q    [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [PC_W-1:0] target_q [ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;

   entry_t lk_entry;
   entry_t upd_entry;

   logic lk_match;
   logic upd_match;
   logic upd_hit;
   logic upd_alloc;
   logic upd_write_data;

   logic unused_pc_bits;

   assign lk_idx  = lookup_pc_i[IDX_W+1:2];
   assign lk_tag  = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
   assign upd_idx = upd_pc_i[IDX_W+1:2];
   assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

   // Byte-offset bits and PC bits above the tag never take part in the lookup.
   assign unused_pc_bits = ^{lookup_pc_i, upd_pc_i};

   always_comb begin
      lk_entry.valid   = valid_q[lk_idx];
      lk_entry.tag     = tag_q[lk_idx];
      lk_entry.ctr     = ctr_q[lk_idx];
      lk_entry.target  = target_q[lk_idx];
      upd_entry.valid  = valid_q[upd_idx];
      upd_entry.tag    = tag_q[upd_idx];
      upd_entry.ctr    = ctr_q[upd_idx];
      upd_entry.target = target_q[upd_idx];
   end

   btb_tag_cmp #(
      .TAG_W(TAG_W)
   ) u_lookup_cmp (
      .entry_valid(lk_entry.valid),
      .entry_tag  (lk_entry.tag),
      .pc_tag     (lk_tag),
      .match      (lk_match)
   );

   btb_tag_cmp #(
      .TAG_W(TAG_W)
   ) u_update_cmp (
      .entry_valid(upd_entry.valid),
      .entry_tag  (upd_entry.tag),
      .pc_tag     (upd_tag),
      .match      (upd_match)
   );

   assign upd_hit        = upd_valid_i & upd_match;
   assign upd_alloc      = upd_valid_i & ~upd_match & upd_taken_i;
   assign upd_write_data = ~flush_i & upd_valid_i & upd_taken_i;

   // Prediction registers read the table before this cycle's update lands,
   // so a same-index lookup and update see the old contents.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pred_valid_o  <= 1'b0;
         pred_hit_o    <= 1'b0;
         pred_taken_o  <= 1'b0;
         pred_target_o <= '0;
      end else if (flush_i) begin
         pred_valid_o  <= 1'b0;
         pred_hit_o    <= 1'b0;
         pred_taken_o  <= 1'b0;
         pred_target_o <= '0;
      end else begin
         pred_valid_o  <= lookup_valid_i;
         pred_hit_o    <= lookup_valid_i & lk_match;
         pred_taken_o  <= lookup_valid_i & lk_match & lk_entry.ctr[1];
         pred_target_o <= (lookup_valid_i & lk_match) ? lk_entry.target : '0;
      end
   end

   // Flush wins over a same-cycle update and leaves the counters untouched.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= WN;
         end
      end else if (flush_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (upd_hit) begin
         ctr_q[upd_idx] <= sat_update(upd_entry.ctr, upd_taken_i);
      end else if (upd_alloc) begin
         valid_q[upd_idx] <= 1'b1;
         ctr_q[upd_idx]   <= CTR_INIT;
      end
   end

   // Every taken update either allocates or retargets; on a hit the tag
   // rewrite stores the value already present.
   always_ff @(posedge clk_i) begin
      if (upd_write_data) begin
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= upd_target_i;
      end
   end

endmodule

// File: tb/tb_btb_2bit_pred.sv
// Self-checking bench for btb_2bit_pred: directed scenarios followed by random
// traffic, all compared against a table model built from the field/counter rules.
module tb_btb_2bit_pred;

   localparam int PC_W    = 32;
   localparam int ENTRIES = 16;

   logic            clk_i;
   logic            rst_i;
   logic            lookup_valid_i;
   logic [PC_W-1:0] lookup_pc_i;
   logic            pred_valid_o;
   logic            pred_hit_o;
   logic            pred_taken_o;
   logic [PC_W-1:0] pred_target_o;
   logic            upd_valid_i;
   logic [PC_W-1:0] upd_pc_i;
   logic            upd_taken_i;
   logic [PC_W-1:0] upd_target_i;
   logic            flush_i;

   int testsRun;
   int testsFailed;

   bit              mValid  [ENTRIES];
   int              mTag    [ENTRIES];
   int              mCount  [ENTRIES];
   logic [PC_W-1:0] mTarget [ENTRIES];

   btb_2bit_pred dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .lookup_valid_i(lookup_valid_i),
      .lookup_pc_i   (lookup_pc_i),
      .pred_valid_o  (pred_valid_o),
      .pred_hit_o    (pred_hit_o),
      .pred_taken_o  (pred_taken_o),
      .pred_target_o (pred_target_o),
      .upd_valid_i   (upd_valid_i),
      .upd_pc_i      (upd_pc_i),
      .upd_taken_i   (upd_taken_i),
      .upd_target_i  (upd_target_i),
      .flush_i       (flush_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic int pcIndex(input logic [PC_W-1:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic int pcTag(input logic [PC_W-1:0] pc);
      return int'((pc / 64) % 16);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < ENTRIES; i++) begin
         mValid[i]  = 1'b0;
         mCount[i]  = 1;
         mTag[i]    = 0;
         mTarget[i] = '0;
      end
   endtask

   task automatic checkOutput(input string name, input bit eValid, input bit eHit,
                              input bit eTaken, input logic [PC_W-1:0] eTarget);
      testsRun++;
      assert (pred_valid_o === eValid) else begin
         testsFailed++;
         $error("[TB] FAIL %s valid: observed %0b expected %0b", name, pred_valid_o, eValid);
      end
      testsRun++;
      assert (pred_hit_o === eHit) else begin
         testsFailed++;
         $error("[TB] FAIL %s hit: observed %0b expected %0b", name, pred_hit_o, eHit);
      end
      testsRun++;
      assert (pred_taken_o === eTaken) else begin
         testsFailed++;
         $error("[TB] FAIL %s taken: observed %0b expected %0b", name, pred_taken_o, eTaken);
      end
      testsRun++;
      assert (pred_target_o === eTarget) else begin
         testsFailed++;
         $error("[TB] FAIL %s target: observed %h expected %h", name, pred_target_o, eTarget);
      end
   endtask

   // One clock of traffic: predict from the model as it stands, then apply the update.
   task automatic applyStimulus(input string name, input bit lv, input logic [PC_W-1:0] lpc,
                                input bit uv, input logic [PC_W-1:0] upc, input bit ut,
                                input logic [PC_W-1:0] utgt, input bit fl);
      bit              eValid;
      bit              eHit;
      bit              eTaken;
      logic [PC_W-1:0] eTarget;
      int              li;
      int              ui;
      bit              uHit;

      lookup_valid_i = lv;
      lookup_pc_i    = lpc;
      upd_valid_i    = uv;
      upd_pc_i       = upc;
      upd_taken_i    = ut;
      upd_target_i   = utgt;
      flush_i        = fl;

      li      = pcIndex(lpc);
      eValid  = lv && !fl;
      eHit    = eValid && mValid[li] && (mTag[li] == pcTag(lpc));
      eTaken  = eHit && (mCount[li] >= 2);
      eTarget = eHit ? mTarget[li] : '0;

      ui   = pcIndex(upc);
      uHit = mValid[ui] && (mTag[ui] == pcTag(upc));
      if (fl) begin
         for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
      end else if (uv) begin
         if (uHit) begin
            if (ut) begin
               mCount[ui]  = (mCount[ui] == 3) ? 3 : mCount[ui] + 1;
               mTarget[ui] = utgt;
            end else begin
               mCount[ui] = (mCount[ui] == 0) ? 0 : mCount[ui] - 1;
            end
         end else if (ut) begin
            mValid[ui]  = 1'b1;
            mTag[ui]    = pcTag(upc);
            mTarget[ui] = utgt;
            mCount[ui]  = 2;
         end
      end

      @(posedge clk_i);
      #1;
      checkOutput(name, eValid, eHit, eTaken, eTarget);
      lookup_valid_i = 1'b0;
      upd_valid_i    = 1'b0;
      flush_i        = 1'b0;
   endtask

   initial begin
      logic [PC_W-1:0] rpc;
      logic [PC_W-1:0] rupc;

      testsRun       = 0;
      testsFailed    = 0;
      rst_i          = 1'b1;
      lookup_valid_i = 1'b0;
      lookup_pc_i    = '0;
      upd_valid_i    = 1'b0;
      upd_pc_i       = '0;
      upd_taken_i    = 1'b0;
      upd_target_i   = '0;
      flush_i        = 1'b0;
      modelReset();

      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("reset", 1'b0, 1'b0, 1'b0, '0);
      rst_i = 1'b0;

      applyStimulus("cold_miss", 1, 32'h40, 0, 0, 0, 0, 0);
      applyStimulus("alloc_40", 0, 0, 1, 32'h40, 1, 32'h100, 0);
      applyStimulus("hit_40", 1, 32'h40, 0, 0, 0, 0, 0);

      for (int n = 0; n < 3; n++) begin
         applyStimulus("train_nt", 0, 0, 1, 32'h40, 0, 32'hdead_0000, 0);
         applyStimulus("look_nt", 1, 32'h40, 0, 0, 0, 0, 0);
      end
      for (int n = 0; n < 4; n++) begin
         applyStimulus("train_t", 0, 0, 1, 32'h40, 1, 32'h100 + 32'(n * 16), 0);
         applyStimulus("look_t", 1, 32'h40, 0, 0, 0, 0, 0);
      end
      applyStimulus("sat_nt", 0, 0, 1, 32'h40, 0, 0, 0);
      applyStimulus("look_sat", 1, 32'h40, 0, 0, 0, 0, 0);

      applyStimulus("alloc_40b", 0, 0, 1, 32'h40, 1, 32'h100, 0);
      applyStimulus("alloc_140", 0, 0, 1, 32'h140, 1, 32'h200, 0);
      applyStimulus("alias_40", 1, 32'h40, 0, 0, 0, 0, 0);
      applyStimulus("alias_140", 1, 32'h140, 0, 0, 0, 0, 0);
      applyStimulus("alloc_440", 0, 0, 1, 32'h440, 1, 32'h300, 0);
      applyStimulus("alias_440", 1, 32'h440, 0, 0, 0, 0, 0);

      applyStimulus("rbw_80", 1, 32'h80, 1, 32'h80, 1, 32'h880, 0);
      applyStimulus("after_80", 1, 32'h80, 0, 0, 0, 0, 0);

      applyStimulus("flush_upd", 1, 32'h80, 1, 32'h40, 1, 32'h500, 1);
      applyStimulus("post_fl_40", 1, 32'h40, 0, 0, 0, 0, 0);
      applyStimulus("post_fl_80", 1, 32'h80, 0, 0, 0, 0, 0);
      applyStimulus("post_fl_440", 1, 32'h440, 0, 0, 0, 0, 0);
      applyStimulus("idle", 0, 32'h440, 0, 0, 0, 0, 0);

      for (int n = 0; n < 400; n++) begin
         rpc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
                | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 1)) << 12);
         rupc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
                | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 1)) << 12);
         applyStimulus("random", bit'($urandom_range(0, 3) != 0), rpc,
                       bit'($urandom_range(0, 1)), rupc, bit'($urandom_range(0, 2) != 0),
                       32'($urandom), bit'($urandom_range(0, 40) == 0));
      end

      applyStimulus("pre_rst_alloc", 0, 0, 1, 32'hc0, 1, 32'h7000, 0);
      lookup_valid_i = 1'b1;
      lookup_pc_i    = 32'hc0;
      @(posedge clk_i);
      #1;
      checkOutput("pre_rst_hit", 1'b1, 1'b1, 1'b1, 32'h7000);
      #2;
      rst_i = 1'b1;
      #1;
      modelReset();
      checkOutput("async_rst", 1'b0, 1'b0, 1'b0, '0);
      lookup_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      checkOutput("rst_release", 1'b0, 1'b0, 1'b0, '0);
      applyStimulus("rst_miss", 1, 32'hc0, 0, 0, 0, 0, 0);
      applyStimulus("rst_realloc", 0, 0, 1, 32'hc0, 1, 32'h7100, 0);
      applyStimulus("rst_hit", 1, 32'hc0, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
